// File: rtl/bip_debug_unit.sv
// -----------------------------------------------------------------------------
// bip_debug_unit
//
// Run-control and result-dump stage between the UART byte interfaces and the
// accumulator core. The core is held idle until the host sends 'G' (run to
// HALT) or 'S' (single step). The core is advanced through a clock enable, and
// executed cycles are counted with saturation. When the run or step ends, a
// 6-byte snapshot {PC, ACC, CNT} is sent MSB first through the UART transmitter.
//
// Ports
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   rx_data    received byte from UART RX
//   rx_valid   one-cycle strobe, rx_data valid
//   tx_data    byte to transmit (valid with tx_start)
//   tx_start   one-cycle strobe to UART TX
//   tx_busy    UART TX busy (rises the cycle after tx_start)
//   opcode     opcode of the current instruction word; 0 is HALT
//   pc         core program counter
//   acc        core accumulator
//   cpu_en     core clock enable
//   cpu_clear  one-cycle synchronous clear of core PC/ACC
//   done       high while the unit sits in DONE after a HALT
// -----------------------------------------------------------------------------
module bip_debug_unit #(
  parameter int PC_W   = 11,
  parameter int DATA_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic [7:0]        tx_data,
  output logic              tx_start,
  input  logic              tx_busy,
  input  logic [4:0]        opcode,
  input  logic [PC_W-1:0]   pc,
  input  logic [DATA_W-1:0] acc,
  output logic              cpu_en,
  output logic              cpu_clear,
  output logic              done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_RUN,
    S_STEP,
    S_LOAD,
    S_SEND,
    S_WAIT,
    S_DONE
  } state_t;

  state_t              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [PC_W-1:0]     r_snap_pc;
  logic [DATA_W-1:0]   r_snap_acc;
  logic [CNT_W-1:0]    r_snap_cnt;
  logic [2:0]          r_idx;
  logic                r_skip;
  logic                r_halted;

  logic                w_is_halt;
  logic                w_cmd_go;
  logic                w_cmd_step;
  logic                w_cpu_en;
  logic [15:0]         w_pc16;
  logic [15:0]         w_acc16;
  logic [15:0]         w_cnt16;

  // The counter sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign w_is_halt  = (opcode == 5'b00000);
  assign w_cmd_go   = rx_valid && (rx_data == 8'h47);
  assign w_cmd_step = rx_valid && (rx_data == 8'h53);

  // The enable is combinational so the HALT word is never executed: it is
  // gated off in the same cycle it becomes visible.
  assign w_cpu_en  = ((r_state == S_RUN) || (r_state == S_STEP)) && !w_is_halt;

  assign cpu_en    = w_cpu_en;
  assign cpu_clear = (r_state == S_CLEAR);
  assign done      = (r_state == S_DONE);
  assign tx_start  = (r_state == S_SEND) && !tx_busy;

  // Frame fields are zero-extended to 16 bits so each splits into two bytes.
  assign w_pc16  = 16'(r_snap_pc);
  assign w_acc16 = 16'(r_snap_acc);
  assign w_cnt16 = 16'(r_snap_cnt);

  always_comb begin
    tx_data = 8'h00;
    case (r_idx)
      3'd0:    tx_data = w_pc16[15:8];
      3'd1:    tx_data = w_pc16[7:0];
      3'd2:    tx_data = w_acc16[15:8];
      3'd3:    tx_data = w_acc16[7:0];
      3'd4:    tx_data = w_cnt16[15:8];
      3'd5:    tx_data = w_cnt16[7:0];
      default: tx_data = 8'h00;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_snap_pc  <= '0;
      r_snap_acc <= '0;
      r_snap_cnt <= '0;
      r_idx      <= '0;
      r_skip     <= 1'b0;
      r_halted   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_cmd_go)
            r_state <= S_CLEAR;
          else if (w_cmd_step)
            r_state <= S_STEP;
        end

        S_CLEAR: begin
          r_cnt    <= '0;
          r_halted <= 1'b0;
          r_state  <= S_RUN;
        end

        S_RUN: begin
          if (w_is_halt) begin
            r_halted <= 1'b1;
            r_state  <= S_LOAD;
          end else begin
            r_cnt <= sat_inc(r_cnt);
          end
        end

        S_STEP: begin
          if (w_is_halt)
            r_halted <= 1'b1;
          else
            r_cnt <= sat_inc(r_cnt);
          r_state <= S_LOAD;
        end

        S_LOAD: begin
          r_snap_pc  <= pc;
          r_snap_acc <= acc;
          r_snap_cnt <= r_cnt;
          r_idx      <= '0;
          r_state    <= S_SEND;
        end

        S_SEND: begin
          if (!tx_busy) begin
            r_skip  <= 1'b1;
            r_state <= S_WAIT;
          end
        end

        // The first WAIT cycle is skipped because tx_busy only rises the
        // cycle after tx_start.
        S_WAIT: begin
          if (r_skip) begin
            r_skip <= 1'b0;
          end else if (!tx_busy) begin
            if (r_idx == 3'd5) begin
              r_state <= r_halted ? S_DONE : S_IDLE;
            end else begin
              r_idx   <= r_idx + 3'd1;
              r_state <= S_SEND;
            end
          end
        end

        S_DONE: begin
          if (w_cmd_go)
            r_state <= S_CLEAR;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bip_debug_unit.sv
// -----------------------------------------------------------------------------
// tb_bip_debug_unit
//
// Directed bench for bip_debug_unit. A tiny core model advances a step count
// on cpu_en and presents opcode/pc/acc derived from it; a UART TX model holds
// tx_busy high for busy_len cycles after each tx_start. A negedge monitor
// records transmitted bytes and counts enables, clears and protocol errors.
// -----------------------------------------------------------------------------
module tb_bip_debug_unit;

  logic        clk;
  logic        rst_n;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_busy;
  logic [4:0]  opcode;
  logic [10:0] pc;
  logic [15:0] acc;
  logic        cpu_en;
  logic        cpu_clear;
  logic        done;

  bip_debug_unit #(.PC_W(11), .DATA_W(16), .CNT_W(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .tx_data   (tx_data),
    .tx_start  (tx_start),
    .tx_busy   (tx_busy),
    .opcode    (opcode),
    .pc        (pc),
    .acc       (acc),
    .cpu_en    (cpu_en),
    .cpu_clear (cpu_clear),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Core model: executed-instruction count drives pc/acc; HALT appears once
  // halt_after instructions have executed.
  int unsigned steps;
  int unsigned halt_after;
  int unsigned acc_add;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)         steps <= 0;
    else if (cpu_clear) steps <= 0;
    else if (cpu_en)    steps <= steps + 1;
  end

  assign pc     = steps[10:0];
  assign acc    = 16'(steps * acc_add);
  assign opcode = (steps >= halt_after) ? 5'd0 : 5'd3;

  // UART TX model.
  int busy_len;
  int busy_cnt;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)             busy_cnt <= 0;
    else if (tx_start)      busy_cnt <= busy_len;
    else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
  end

  assign tx_busy = (busy_cnt != 0);

  // Monitor.
  logic [7:0] fr [0:255];
  int n_tx, en_cnt, clr_cnt, both_cnt, viol;

  initial begin
    n_tx = 0; en_cnt = 0; clr_cnt = 0; both_cnt = 0; viol = 0;
  end

  always @(negedge clk) begin
    if (cpu_en)               en_cnt   <= en_cnt + 1;
    if (cpu_clear)            clr_cnt  <= clr_cnt + 1;
    if (cpu_en && cpu_clear)  both_cnt <= both_cnt + 1;
    if (tx_start) begin
      fr[n_tx[7:0]] <= tx_data;
      n_tx          <= n_tx + 1;
      if (tx_busy) viol <= viol + 1;
    end
  end

  int n_vec;
  int n_err;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic wait_frame(input string tag, input int base, input int budget);
    int k;
    k = 0;
    while ((n_tx < base + 6) && (k < budget)) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_complete"}, 32'(n_tx >= base + 6), 32'd1);
    repeat (busy_len + 6) @(negedge clk);
  endtask

  task automatic check_frame(input string tag, input int base, input logic [47:0] exp);
    for (int i = 0; i < 6; i++)
      chk($sformatf("%s_b%0d", tag, i), 32'(fr[8'(base + i)]), 32'(exp[47 - 8*i -: 8]));
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  int base, base_en, base_clr;

  initial begin
    n_vec      = 0;
    n_err      = 0;
    rst_n      = 1'b0;
    rx_valid   = 1'b0;
    rx_data    = 8'h00;
    busy_len   = 1;
    halt_after = 3;
    acc_add    = 6;

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_cpu_en",    32'(cpu_en),    32'd0);
    chk("rst_cpu_clear", 32'(cpu_clear), 32'd0);
    chk("rst_tx_start",  32'(tx_start),  32'd0);
    chk("rst_tx_data",   32'(tx_data),   32'd0);
    chk("rst_done",      32'(done),      32'd0);
    rst_n = 1'b1;

    // Reset in the middle of a long run
    halt_after = 1000;
    send_byte(8'h47);
    repeat (10) @(negedge clk);
    chk("midrun_en", 32'(cpu_en), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_cpu_en",   32'(cpu_en),    32'd0);
    chk("midrst_done",     32'(done),      32'd0);
    chk("midrst_tx_start", 32'(tx_start),  32'd0);
    chk("midrst_clear",    32'(cpu_clear), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic run: three instructions then HALT
    halt_after = 3;
    acc_add    = 6;
    base = n_tx; base_en = en_cnt; base_clr = clr_cnt;
    send_byte(8'h47);
    chk("go_clear_hi", 32'(cpu_clear), 32'd1);
    chk("go_en_lo",    32'(cpu_en),    32'd0);
    @(negedge clk);
    chk("go_clear_lo", 32'(cpu_clear), 32'd0);
    chk("go_en_hi",    32'(cpu_en),    32'd1);
    wait_frame("run", base, 200);
    check_frame("run", base, 48'h0003_0012_0003);
    chk("run_en_cycles", 32'(en_cnt - base_en),   32'd3);
    chk("run_clears",    32'(clr_cnt - base_clr), 32'd1);
    chk("run_done",      32'(done),               32'd1);

    // 'S' ignored in DONE
    base = n_tx; base_en = en_cnt;
    send_byte(8'h53);
    repeat (10) @(negedge clk);
    chk("done_s_tx",   32'(n_tx - base),     32'd0);
    chk("done_s_en",   32'(en_cnt - base_en), 32'd0);
    chk("done_s_done", 32'(done),             32'd1);

    // Single steps from IDLE
    pulse_reset();
    halt_after = 100;
    acc_add    = 5;
    base = n_tx;
    send_byte(8'h53);
    chk("step_en_hi", 32'(cpu_en), 32'd1);
    @(negedge clk);
    chk("step_load_en_lo", 32'(cpu_en), 32'd0);
    @(negedge clk);
    chk("step_first_start", 32'(tx_start), 32'd1);
    wait_frame("step1", base, 200);
    check_frame("step1", base, 48'h0001_0005_0001);
    chk("step1_done", 32'(done), 32'd0);
    base = n_tx;
    send_byte(8'h53);
    wait_frame("step2", base, 200);
    check_frame("step2", base, 48'h0002_000A_0002);
    chk("step2_done", 32'(done), 32'd0);

    // Unknown byte in IDLE
    base = n_tx; base_en = en_cnt; base_clr = clr_cnt;
    send_byte(8'h41);
    repeat (8) @(negedge clk);
    chk("junk_tx",    32'(n_tx - base),         32'd0);
    chk("junk_en",    32'(en_cnt - base_en),    32'd0);
    chk("junk_clear", 32'(clr_cnt - base_clr),  32'd0);

    // Backpressure, with 'G' arriving mid-frame
    busy_len = 20;
    base = n_tx; base_clr = clr_cnt;
    send_byte(8'h53);
    for (int k = 0; (k < 500) && (n_tx < base + 2); k++) @(negedge clk);
    send_byte(8'h47);
    wait_frame("bp", base, 1000);
    check_frame("bp", base, 48'h0003_000F_0003);
    chk("bp_starts", 32'(n_tx - base),        32'd6);
    chk("bp_viol",   32'(viol),               32'd0);
    chk("bp_clear",  32'(clr_cnt - base_clr), 32'd0);
    chk("bp_done",   32'(done),               32'd0);
    busy_len = 1;

    // Step onto a HALT word
    halt_after = 3;
    base = n_tx; base_en = en_cnt;
    send_byte(8'h53);
    chk("hstep_en_lo", 32'(cpu_en), 32'd0);
    wait_frame("hstep", base, 200);
    check_frame("hstep", base, 48'h0003_000F_0003);
    chk("hstep_en_cycles", 32'(en_cnt - base_en), 32'd0);
    chk("hstep_done",      32'(done),             32'd1);
    base = n_tx;
    send_byte(8'h53);
    repeat (10) @(negedge clk);
    chk("hstep_s_ignored", 32'(n_tx - base), 32'd0);
    acc_add = 6;
    base = n_tx;
    send_byte(8'h47);
    wait_frame("restart", base, 200);
    check_frame("restart", base, 48'h0003_0012_0003);
    chk("restart_done", 32'(done), 32'd1);

    // Long run: counter saturates
    halt_after = 66000;
    acc_add    = 1;
    base = n_tx;
    send_byte(8'h47);
    wait_frame("sat", base, 70000);
    check_frame("sat", base, 48'h01D0_01D0_FFFF);
    chk("sat_done", 32'(done), 32'd1);

    chk("en_clear_overlap", 32'(both_cnt), 32'd0);
    chk("start_while_busy", 32'(viol),     32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
